// File: rtl/tank_move_if.sv
// Tank motion controller bundle: frame strobe, keys and collision in,
// position/facing out.
interface tank_move_if;
  logic        startOfFrame;
  logic        keyUp;
  logic        keyRight;
  logic        keyDown;
  logic        keyLeft;
  logic        collision;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic [1:0]  tankDir;
  logic        moving;

  modport master (
    output startOfFrame, keyUp, keyRight,
    output keyDown, keyLeft, collision,
    input  topLeftX, topLeftY, tankDir, moving
  );

  modport slave (
    input  startOfFrame, keyUp, keyRight,
    input  keyDown, keyLeft, collision,
    output topLeftX, topLeftY, tankDir, moving
  );
endinterface

// File: rtl/tank_move_controller.sv
// Per-frame tank motion: key decode, clamped stepping and
// one-deep collision rollback, all committed on startOfFrame.
module tank_move_controller #(
  parameter int         INIT_X      = 100,
  parameter int         INIT_Y      = 400,
  parameter logic [1:0] INIT_DIR    = 2'b00,
  parameter int         SPEED       = 2,
  parameter int         SCREEN_W    = 640,
  parameter int         SCREEN_H    = 480,
  parameter int         OBJECT_SIZE = 25
) (
  input logic        clk,
  input logic        resetN,
  tank_move_if.slave bus
);

  localparam logic [11:0] SPD  = 12'(SPEED);
  localparam logic [11:0] XMAX = 12'(SCREEN_W - OBJECT_SIZE);
  localparam logic [11:0] YMAX = 12'(SCREEN_H - OBJECT_SIZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE    = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [10:0] lx_q, lx_d, ly_q, ly_d;
  logic [1:0]  dir_q, dir_d, bdir_q, bdir_d;
  logic        col_q, col_d;

  logic        key_valid;
  logic [1:0]  key_dir;
  logic [11:0] x12, y12;
  logic [10:0] x_step, y_step;

  always_comb begin
    key_valid = bus.keyUp | bus.keyRight
              | bus.keyDown | bus.keyLeft;
    key_dir = 2'b00;
    priority case (1'b1)
      bus.keyUp:    key_dir = 2'b00;
      bus.keyRight: key_dir = 2'b01;
      bus.keyDown:  key_dir = 2'b10;
      bus.keyLeft:  key_dir = 2'b11;
      default:      key_dir = 2'b00;
    endcase
  end

  // Widen so the right/down sum cannot wrap before the clamp
  always_comb begin
    x12    = {1'b0, x_q};
    y12    = {1'b0, y_q};
    x_step = x_q;
    y_step = y_q;
    unique case (dir_q)
      2'b00: y_step = (y12 < SPD) ? '0
                    : 11'(y12 - SPD);
      2'b01: x_step = (x12 + SPD > XMAX) ? 11'(XMAX)
                    : 11'(x12 + SPD);
      2'b10: y_step = (y12 + SPD > YMAX) ? 11'(YMAX)
                    : 11'(y12 + SPD);
      2'b11: x_step = (x12 < SPD) ? '0
                    : 11'(x12 - SPD);
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    lx_d    = lx_q;
    ly_d    = ly_q;
    dir_d   = dir_q;
    bdir_d  = bdir_q;
    col_d   = col_q | bus.collision;
    if (bus.startOfFrame) begin
      col_d = 1'b0;
      if (col_q | bus.collision) begin
        x_d     = lx_q;
        y_d     = ly_q;
        bdir_d  = dir_q;
        state_d = BLOCKED;
      end else if (!key_valid) begin
        state_d = IDLE;
      end else if (key_dir != dir_q) begin
        dir_d   = key_dir;
        state_d = IDLE;
      end else if (state_q == BLOCKED &&
                   key_dir == bdir_q) begin
        state_d = BLOCKED;
      end else begin
        lx_d    = x_q;
        ly_d    = y_q;
        x_d     = x_step;
        y_d     = y_step;
        state_d = MOVE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      x_q     <= 11'(INIT_X);
      y_q     <= 11'(INIT_Y);
      lx_q    <= 11'(INIT_X);
      ly_q    <= 11'(INIT_Y);
      dir_q   <= INIT_DIR;
      bdir_q  <= INIT_DIR;
      col_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lx_q    <= lx_d;
      ly_q    <= ly_d;
      dir_q   <= dir_d;
      bdir_q  <= bdir_d;
      col_q   <= col_d;
    end
  end

  assign bus.topLeftX = x_q;
  assign bus.topLeftY = y_q;
  assign bus.tankDir  = dir_q;
  assign bus.moving   = (state_q == MOVE);

endmodule

// File: tb/tb_tank_move_controller.sv
// Scoreboard bench for tank_move_controller: frames queue expectations,
// a monitor checks outputs the cycle after each startOfFrame.
module tb_tank_move_controller;

  localparam logic [3:0] K_NONE  = 4'b0000;
  localparam logic [3:0] K_UP    = 4'b1000;
  localparam logic [3:0] K_RIGHT = 4'b0100;
  localparam logic [3:0] K_DOWN  = 4'b0010;
  localparam logic [3:0] K_LEFT  = 4'b0001;

  typedef struct {
    bit          chk;
    logic [10:0] x;
    logic [10:0] y;
    logic [1:0]  d;
    logic        m;
  } exp_t;

  logic clk;
  logic resetN;
  int   n_cmp;
  int   n_bad;
  int   fnum;
  exp_t exq[$];

  tank_move_if bus ();

  tank_move_controller dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [10:0] ex,
                       input logic [10:0] ey,
                       input logic [1:0] ed,
                       input logic em);
    n_cmp++;
    if (bus.topLeftX !== ex || bus.topLeftY !== ey ||
        bus.tankDir !== ed || bus.moving !== em) begin
      n_bad++;
      $display("FAIL %s: got x=%0d y=%0d dir=%b mov=%b want x=%0d y=%0d dir=%b mov=%b",
               nm, bus.topLeftX, bus.topLeftY, bus.tankDir,
               bus.moving, ex, ey, ed, em);
    end
  endtask

  always @(posedge clk) begin
    if (resetN && bus.startOfFrame) begin
      exp_t e;
      @(negedge clk);
      fnum++;
      if (exq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL frame%0d: got output with empty scoreboard", fnum);
      end else begin
        e = exq.pop_front();
        if (e.chk)
          check($sformatf("frame%0d", fnum), e.x, e.y, e.d, e.m);
      end
    end
  end

  task automatic frame(input logic [3:0] k,
                       input bit cmid,
                       input bit csof,
                       input bit chk,
                       input int ex,
                       input int ey,
                       input logic [1:0] ed,
                       input logic em);
    exp_t e;
    e.chk = chk;
    e.x   = 11'(ex);
    e.y   = 11'(ey);
    e.d   = ed;
    e.m   = em;
    exq.push_back(e);
    {bus.keyUp, bus.keyRight, bus.keyDown, bus.keyLeft} = k;
    bus.startOfFrame = 1'b1;
    bus.collision    = csof;
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    bus.collision    = 1'b0;
    @(negedge clk);
    bus.collision = cmid;
    @(negedge clk);
    bus.collision = 1'b0;
    @(negedge clk);
  endtask

  task automatic walk(input logic [3:0] k, input int n);
    repeat (n) frame(k, 0, 0, 0, 0, 0, 2'b00, 1'b0);
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    fnum   = 0;
    resetN = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.collision    = 1'b0;
    {bus.keyUp, bus.keyRight, bus.keyDown, bus.keyLeft} = K_NONE;
    repeat (2) @(negedge clk);
    check("reset", 100, 400, 2'b00, 1'b0);
    resetN = 1'b1;
    @(negedge clk);

    // keyUp held, already facing up
    frame(K_UP, 0, 0, 1, 100, 398, 2'b00, 1'b1);
    frame(K_UP, 0, 0, 1, 100, 396, 2'b00, 1'b1);
    frame(K_UP, 0, 0, 1, 100, 394, 2'b00, 1'b1);
    // turn right in place, then step
    frame(K_RIGHT, 0, 0, 1, 100, 394, 2'b01, 1'b0);
    frame(K_RIGHT, 0, 0, 1, 102, 394, 2'b01, 1'b1);
    // turn up, step with a mid-frame collision
    frame(K_UP, 0, 0, 1, 102, 394, 2'b00, 1'b0);
    frame(K_UP, 1, 0, 1, 102, 392, 2'b00, 1'b1);
    frame(K_UP, 0, 0, 1, 102, 394, 2'b00, 1'b0);
    frame(K_UP, 0, 0, 1, 102, 394, 2'b00, 1'b0);
    frame(K_UP, 0, 0, 1, 102, 394, 2'b00, 1'b0);
    // release, turn left, step
    frame(K_NONE, 0, 0, 1, 102, 394, 2'b00, 1'b0);
    frame(K_LEFT, 0, 0, 1, 102, 394, 2'b11, 1'b0);
    frame(K_LEFT, 0, 0, 1, 100, 394, 2'b11, 1'b1);
    // two consecutive collision frames roll back to same spot
    frame(K_LEFT, 1, 0, 1, 98, 394, 2'b11, 1'b1);
    frame(K_LEFT, 1, 0, 1, 100, 394, 2'b11, 1'b0);
    frame(K_LEFT, 0, 0, 1, 100, 394, 2'b11, 1'b0);
    // up wins over left; collision on the startOfFrame cycle
    frame(K_NONE, 0, 0, 1, 100, 394, 2'b11, 1'b0);
    frame(K_UP | K_LEFT, 0, 0, 1, 100, 394, 2'b00, 1'b0);
    frame(K_UP | K_LEFT, 0, 0, 1, 100, 392, 2'b00, 1'b1);
    frame(K_UP, 0, 1, 1, 100, 394, 2'b00, 1'b0);
    frame(K_UP, 0, 0, 1, 100, 394, 2'b00, 1'b0);
    frame(K_NONE, 0, 0, 1, 100, 394, 2'b00, 1'b0);
    frame(K_UP, 0, 0, 1, 100, 392, 2'b00, 1'b1);
    // right edge clamp at 615
    frame(K_RIGHT, 0, 0, 1, 100, 392, 2'b01, 1'b0);
    walk(K_RIGHT, 256);
    frame(K_RIGHT, 0, 0, 1, 614, 392, 2'b01, 1'b1);
    frame(K_RIGHT, 0, 0, 1, 615, 392, 2'b01, 1'b1);
    frame(K_RIGHT, 0, 0, 1, 615, 392, 2'b01, 1'b1);
    // bottom edge clamp at 455
    frame(K_DOWN, 0, 0, 1, 615, 392, 2'b10, 1'b0);
    walk(K_DOWN, 31);
    frame(K_DOWN, 0, 0, 1, 615, 455, 2'b10, 1'b1);
    frame(K_DOWN, 0, 0, 1, 615, 455, 2'b10, 1'b1);
    // top edge: odd Y reaches 1 then clamps to 0
    frame(K_UP, 0, 0, 1, 615, 455, 2'b00, 1'b0);
    walk(K_UP, 226);
    frame(K_UP, 0, 0, 1, 615, 1, 2'b00, 1'b1);
    frame(K_UP, 0, 0, 1, 615, 0, 2'b00, 1'b1);
    frame(K_UP, 0, 0, 1, 615, 0, 2'b00, 1'b1);

    // async reset mid-frame discards a pending collision
    bus.collision = 1'b1;
    @(negedge clk);
    bus.collision = 1'b0;
    @(negedge clk);
    #2 resetN = 1'b0;
    #1 check("async_reset", 100, 400, 2'b00, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    frame(K_UP, 0, 0, 1, 100, 398, 2'b00, 1'b1);

    for (int i = 0; i < 20 && exq.size() != 0; i++)
      @(negedge clk);
    if (exq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations want 0",
               exq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
